// File: rtl/txn_dispatcher.sv
// txn_dispatcher: sequencer in front of the cuckoo-hash key/value account store.
// Buffers transfer requests (src key, dst key, amount) in a small FIFO and runs
// each one as a series of single store operations:
//   destination search -> [source search] -> debit source -> credit destination.
// One result (done pulse + status + balances) is reported per transfer.
//
// Optional feature macro: BALANCE_CHECK_EN
//   When defined, a source search is performed before the debit, and transfers
//   whose amount exceeds the source balance finish with NO_FUNDS and never
//   touch the store. When undefined, debits may wrap below zero.

module txn_dispatcher #(
    parameter int FIFO_DEPTH    = 4,
    parameter int STORE_LATENCY = 2,
    parameter int KEY_W         = 32,
    parameter int VAL_W         = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_src_key,
    input  logic [KEY_W-1:0] in_dst_key,
    input  logic [VAL_W-1:0] in_amount,
    output logic [KEY_W-1:0] store_key,
    output logic [1:0]       store_signal,
    output logic [VAL_W-1:0] store_value,
    output logic             store_kind,
    output logic             store_en,
    input  logic             store_hit,
    input  logic [VAL_W-1:0] store_updated_value,
    output logic             done,
    output logic [2:0]       status,
    output logic [VAL_W-1:0] src_balance,
    output logic [VAL_W-1:0] dst_balance
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 2 * KEY_W + VAL_W;
    localparam int CNT_W   = (STORE_LATENCY < 1) ? 1 : $clog2(STORE_LATENCY + 1);

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_SRC_MISS = 3'd1;
    localparam logic [2:0] ST_DST_MISS = 3'd2;
    localparam logic [2:0] ST_NO_FUNDS = 3'd3;
    localparam logic [2:0] ST_SELF     = 3'd4;

    localparam logic [1:0] SIG_SEARCH   = 2'd0;
    localparam logic [1:0] SIG_TRANSACT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_POP      = 3'd1,
        S_DST_SRCH = 3'd2,
        S_SRC_SRCH = 3'd3,
        S_DEBIT    = 3'd4,
        S_CREDIT   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_r;
    logic [AW:0]        rd_ptr_r;

    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic               pop_s;
    logic               push_s;
    logic               in_ready_s;
    logic [ENTRY_W-1:0] head_s;
    logic [KEY_W-1:0]   head_src_s;
    logic [KEY_W-1:0]   head_dst_s;
    logic [VAL_W-1:0]   head_amt_s;

    state_t             state_r;

    // FIFO status, handshake and head-entry decode
    always_comb begin
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s        = (state_r == S_POP);
        // a pop this cycle frees the head slot, so a full FIFO may still accept
        in_ready_s   = (!fifo_full_s) || pop_s;
        push_s       = in_valid && in_ready_s;
        head_s       = fifo_mem_r[rd_ptr_r[AW-1:0]];
        head_src_s   = head_s[ENTRY_W-1 -: KEY_W];
        head_dst_s   = head_s[VAL_W +: KEY_W];
        head_amt_s   = head_s[VAL_W-1:0];
    end

    assign in_ready = in_ready_s;

    // FIFO storage write on accepted push
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= {in_src_key, in_dst_key, in_amount};
        end
    end

    // FIFO pointer update; pop is owned by the POP state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer sequencer
    // ------------------------------------------------------------------
    logic [KEY_W-1:0] cur_src_r;
    logic [KEY_W-1:0] cur_dst_r;
    logic [VAL_W-1:0] cur_amt_r;
    logic [VAL_W-1:0] src_acc_r;
    logic [CNT_W-1:0] wait_cnt_r;

    logic [KEY_W-1:0] store_key_r;
    logic [1:0]       store_signal_r;
    logic [VAL_W-1:0] store_value_r;
    logic             store_kind_r;
    logic             store_en_r;
    logic             done_r;
    logic [2:0]       status_r;
    logic [VAL_W-1:0] src_balance_r;
    logic [VAL_W-1:0] dst_balance_r;

    logic             op_last_s;

    // the store response is valid on the edge after STORE_LATENCY counted edges
    always_comb begin
        op_last_s = (wait_cnt_r == CNT_W'(STORE_LATENCY));
    end

    // Main FSM: command outputs are registered on op entry and held for the op
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= S_IDLE;
            cur_src_r      <= '0;
            cur_dst_r      <= '0;
            cur_amt_r      <= '0;
            src_acc_r      <= '0;
            wait_cnt_r     <= '0;
            store_key_r    <= '0;
            store_signal_r <= 2'd0;
            store_value_r  <= '0;
            store_kind_r   <= 1'b0;
            store_en_r     <= 1'b0;
            done_r         <= 1'b0;
            status_r       <= 3'd0;
            src_balance_r  <= '0;
            dst_balance_r  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r <= S_POP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                S_POP: begin
                    cur_src_r <= head_src_s;
                    cur_dst_r <= head_dst_s;
                    cur_amt_r <= head_amt_s;
                    src_acc_r <= '0;
                    if (head_src_s == head_dst_s) begin
                        state_r       <= S_DONE;
                        done_r        <= 1'b1;
                        status_r      <= ST_SELF;
                        src_balance_r <= '0;
                        dst_balance_r <= '0;
                    end else begin
                        state_r        <= S_DST_SRCH;
                        wait_cnt_r     <= '0;
                        store_en_r     <= 1'b1;
                        store_key_r    <= head_dst_s;
                        store_signal_r <= SIG_SEARCH;
                        store_value_r  <= head_amt_s;
                        store_kind_r   <= 1'b0;
                    end
                end

                S_DST_SRCH: begin
                    if (!op_last_s) begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end else if (!store_hit) begin
                        state_r        <= S_DONE;
                        done_r         <= 1'b1;
                        status_r       <= ST_DST_MISS;
                        src_balance_r  <= '0;
                        dst_balance_r  <= '0;
                        store_en_r     <= 1'b0;
                        store_signal_r <= 2'd0;
                    end else begin
                        wait_cnt_r     <= '0;
                        store_key_r    <= cur_src_r;
                        store_value_r  <= cur_amt_r;
                        store_kind_r   <= 1'b0;
`ifdef BALANCE_CHECK_EN
                        state_r        <= S_SRC_SRCH;
                        store_signal_r <= SIG_SEARCH;
`else
                        state_r        <= S_DEBIT;
                        store_signal_r <= SIG_TRANSACT;
`endif
                    end
                end

`ifdef BALANCE_CHECK_EN
                S_SRC_SRCH: begin
                    if (!op_last_s) begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end else if (!store_hit) begin
                        state_r        <= S_DONE;
                        done_r         <= 1'b1;
                        status_r       <= ST_SRC_MISS;
                        src_balance_r  <= '0;
                        dst_balance_r  <= '0;
                        store_en_r     <= 1'b0;
                        store_signal_r <= 2'd0;
                    end else if (store_updated_value < cur_amt_r) begin
                        state_r        <= S_DONE;
                        done_r         <= 1'b1;
                        status_r       <= ST_NO_FUNDS;
                        src_balance_r  <= store_updated_value;
                        dst_balance_r  <= '0;
                        store_en_r     <= 1'b0;
                        store_signal_r <= 2'd0;
                    end else begin
                        state_r        <= S_DEBIT;
                        wait_cnt_r     <= '0;
                        store_key_r    <= cur_src_r;
                        store_signal_r <= SIG_TRANSACT;
                        store_value_r  <= cur_amt_r;
                        store_kind_r   <= 1'b0;
                    end
                end
`endif

                S_DEBIT: begin
                    if (!op_last_s) begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end else if (!store_hit) begin
                        state_r        <= S_DONE;
                        done_r         <= 1'b1;
                        status_r       <= ST_SRC_MISS;
                        src_balance_r  <= '0;
                        dst_balance_r  <= '0;
                        store_en_r     <= 1'b0;
                        store_signal_r <= 2'd0;
                    end else begin
                        state_r        <= S_CREDIT;
                        wait_cnt_r     <= '0;
                        src_acc_r      <= store_updated_value;
                        store_key_r    <= cur_dst_r;
                        store_signal_r <= SIG_TRANSACT;
                        store_value_r  <= cur_amt_r;
                        store_kind_r   <= 1'b1;
                    end
                end

                S_CREDIT: begin
                    if (!op_last_s) begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end else begin
                        state_r        <= S_DONE;
                        done_r         <= 1'b1;
                        status_r       <= ST_OK;
                        src_balance_r  <= src_acc_r;
                        dst_balance_r  <= store_updated_value;
                        store_en_r     <= 1'b0;
                        store_signal_r <= 2'd0;
                    end
                end

                S_DONE: begin
                    if (!fifo_empty_s) begin
                        state_r <= S_POP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                default: begin
                    state_r        <= S_IDLE;
                    store_en_r     <= 1'b0;
                    store_signal_r <= 2'd0;
                end
            endcase
        end
    end

    assign store_key    = store_key_r;
    assign store_signal = store_signal_r;
    assign store_value  = store_value_r;
    assign store_kind   = store_kind_r;
    assign store_en     = store_en_r;
    assign done         = done_r;
    assign status       = status_r;
    assign src_balance  = src_balance_r;
    assign dst_balance  = dst_balance_r;

endmodule

// File: tb/tb_txn_dispatcher.sv
// tb_txn_dispatcher: directed bench for txn_dispatcher with a behavioural
// account store (accounts 0x11=100, 0x22=50, 0x33=7, 0x44=1000).

module tb_txn_dispatcher;

    localparam int L = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_src_key = 32'h0;
    logic [31:0] in_dst_key = 32'h0;
    logic [31:0] in_amount = 32'h0;
    logic [31:0] store_key;
    logic [1:0]  store_signal;
    logic [31:0] store_value;
    logic        store_kind;
    logic        store_en;
    logic        store_hit;
    logic [31:0] store_updated_value;
    logic        done;
    logic [2:0]  status;
    logic [31:0] src_balance;
    logic [31:0] dst_balance;

    int checks = 0;
    int errors = 0;

    txn_dispatcher #(.FIFO_DEPTH(4), .STORE_LATENCY(L), .KEY_W(32), .VAL_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src_key(in_src_key), .in_dst_key(in_dst_key), .in_amount(in_amount),
        .store_key(store_key), .store_signal(store_signal), .store_value(store_value),
        .store_kind(store_kind), .store_en(store_en),
        .store_hit(store_hit), .store_updated_value(store_updated_value),
        .done(done), .status(status),
        .src_balance(src_balance), .dst_balance(dst_balance)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural store ----------------
    logic [31:0] acct_bal [4];
    int          age = 0;
    int          n_cmds = 0;
    bit          en_seen = 1'b0;
    bit          reload_req = 1'b0;
    logic [1:0]  log_sig  [16];
    logic [31:0] log_key  [16];
    logic        log_kind [16];
    logic [31:0] log_val  [16];
    logic [2:0]  m_look;

    function automatic logic [2:0] find_acct(input logic [31:0] k);
        case (k)
            32'h11:  return 3'b100;
            32'h22:  return 3'b101;
            32'h33:  return 3'b110;
            32'h44:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    assign m_look = find_acct(store_key);

    // store model: responds L edges after a command is presented
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            age                 <= 0;
            store_hit           <= 1'b0;
            store_updated_value <= 32'h0;
        end else begin
            if (reload_req) begin
                acct_bal[0] <= 32'd100;
                acct_bal[1] <= 32'd50;
                acct_bal[2] <= 32'd7;
                acct_bal[3] <= 32'd1000;
                n_cmds      <= 0;
                en_seen     <= 1'b0;
            end else if (store_en) begin
                en_seen <= 1'b1;
            end
            if (store_en && !reload_req) begin
                if (age + 1 == L) begin
                    if (n_cmds < 16) begin
                        log_sig[n_cmds]  <= store_signal;
                        log_key[n_cmds]  <= store_key;
                        log_kind[n_cmds] <= store_kind;
                        log_val[n_cmds]  <= store_value;
                    end
                    n_cmds <= n_cmds + 1;
                    if (!m_look[2]) begin
                        store_hit           <= 1'b0;
                        store_updated_value <= 32'h0;
                    end else if (store_signal == 2'd2) begin
                        store_hit <= 1'b1;
                        if (store_kind) begin
                            acct_bal[m_look[1:0]] <= acct_bal[m_look[1:0]] + store_value;
                            store_updated_value   <= acct_bal[m_look[1:0]] + store_value;
                        end else begin
                            acct_bal[m_look[1:0]] <= acct_bal[m_look[1:0]] - store_value;
                            store_updated_value   <= acct_bal[m_look[1:0]] - store_value;
                        end
                    end else begin
                        store_hit           <= 1'b1;
                        store_updated_value <= acct_bal[m_look[1:0]];
                    end
                end
                age <= (age + 1 == L + 1) ? 0 : age + 1;
            end else begin
                age <= 0;
            end
        end
    end

    // done monitor
    logic [2:0]  mon_status [$];
    logic [31:0] mon_src [$];
    logic [31:0] mon_dst [$];
    int          mon_cnt = 0;

    // capture every result pulse in order
    always @(negedge clock) begin
        if (done === 1'b1) begin
            mon_status.push_back(status);
            mon_src.push_back(src_balance);
            mon_dst.push_back(dst_balance);
            mon_cnt <= mon_cnt + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic reload_tbl;
        @(negedge clock);
        reload_req = 1'b1;
        @(negedge clock);
        reload_req = 1'b0;
    endtask

    task automatic push_req(input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] a, output int waits);
        waits = 0;
        @(negedge clock);
        in_valid = 1'b1; in_src_key = s; in_dst_key = d; in_amount = a;
        while (in_ready !== 1'b1 && waits < 100) begin
            @(negedge clock);
            waits++;
        end
        if (waits >= 100) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waits);
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1 in_valid = 1'b0;
        end
    endtask

    // call right after the accepting edge; cyc = cycle index holding done
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within 300 cycles");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
        checks++; if (store_en !== 1'b0) begin errors++; $display("FAIL rst_store_en: got %b need 0", store_en); end
        checks++; if (done !== 1'b0 || status !== 3'd0) begin errors++; $display("FAIL rst_done_status: got %b/%0d need 0/0", done, status); end
        checks++; if (store_key !== 32'h0 || store_signal !== 2'd0 || src_balance !== 32'h0 || dst_balance !== 32'h0) begin
            errors++; $display("FAIL rst_outputs: key=%h sig=%0d src=%h dst=%h need all 0", store_key, store_signal, src_balance, dst_balance);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_transfer_ok;
        int w, cyc, exp_n, exp_cyc;
        logic [1:0]  es [4];
        logic [31:0] ek [4];
        logic        ed [4];
`ifdef BALANCE_CHECK_EN
        exp_n = 4; exp_cyc = 15;
        es[0] = 2'd0; ek[0] = 32'h22; ed[0] = 1'b0;
        es[1] = 2'd0; ek[1] = 32'h11; ed[1] = 1'b0;
        es[2] = 2'd2; ek[2] = 32'h11; ed[2] = 1'b0;
        es[3] = 2'd2; ek[3] = 32'h22; ed[3] = 1'b1;
`else
        exp_n = 3; exp_cyc = 12;
        es[0] = 2'd0; ek[0] = 32'h22; ed[0] = 1'b0;
        es[1] = 2'd2; ek[1] = 32'h11; ed[1] = 1'b0;
        es[2] = 2'd2; ek[2] = 32'h22; ed[2] = 1'b1;
        es[3] = 2'd0; ek[3] = 32'h0;  ed[3] = 1'b0;
`endif
        reload_tbl();
        push_req(32'h11, 32'h22, 32'd5, w);
        wait_done(cyc);
        checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL ok_latency: done in cycle %0d need %0d", cyc, exp_cyc); end
        checks++; if (status !== 3'd0) begin errors++; $display("FAIL ok_status: got %0d need 0", status); end
        checks++; if (src_balance !== 32'd95 || dst_balance !== 32'd55) begin
            errors++; $display("FAIL ok_balances: got %0d/%0d need 95/55", src_balance, dst_balance);
        end
        @(negedge clock);
        checks++; if (done !== 1'b0 || store_en !== 1'b0) begin errors++; $display("FAIL ok_pulse: done=%b en=%b need 0/0", done, store_en); end
        checks++; if (status !== 3'd0 || src_balance !== 32'd95) begin errors++; $display("FAIL ok_hold: status=%0d src=%0d need 0/95", status, src_balance); end
        checks++; if (n_cmds != exp_n) begin errors++; $display("FAIL ok_ncmds: got %0d need %0d", n_cmds, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (log_sig[i] !== es[i] || log_key[i] !== ek[i] || (es[i] == 2'd2 && (log_kind[i] !== ed[i] || log_val[i] !== 32'd5))) begin
                errors++;
                $display("FAIL ok_cmd%0d: sig=%0d key=%h kind=%b val=%0d need sig=%0d key=%h kind=%b", i,
                         log_sig[i], log_key[i], log_kind[i], log_val[i], es[i], ek[i], ed[i]);
            end
        end
    endtask

    task automatic test_overdraw;
        int w, cyc;
        logic [2:0]  e_st;
        logic [31:0] e_src, e_dst;
        int          e_n;
`ifdef BALANCE_CHECK_EN
        e_st = 3'd3; e_src = 32'd100; e_dst = 32'd0; e_n = 2;
`else
        e_st = 3'd0; e_src = 32'hFFFF_FF9C; e_dst = 32'd250; e_n = 3;
`endif
        reload_tbl();
        push_req(32'h11, 32'h22, 32'd200, w);
        wait_done(cyc);
        checks++; if (status !== e_st) begin errors++; $display("FAIL od_status: got %0d need %0d", status, e_st); end
        checks++; if (src_balance !== e_src || dst_balance !== e_dst) begin
            errors++; $display("FAIL od_balances: got %h/%h need %h/%h", src_balance, dst_balance, e_src, e_dst);
        end
        checks++; if (n_cmds != e_n) begin errors++; $display("FAIL od_ncmds: got %0d need %0d", n_cmds, e_n); end
    endtask

    task automatic test_dst_miss;
        int w, cyc;
        reload_tbl();
        push_req(32'h11, 32'h99, 32'd5, w);
        wait_done(cyc);
        checks++; if (status !== 3'd2) begin errors++; $display("FAIL dm_status: got %0d need 2", status); end
        checks++; if (n_cmds != 1 || acct_bal[0] !== 32'd100) begin
            errors++; $display("FAIL dm_store: cmds=%0d bal11=%0d need 1/100", n_cmds, acct_bal[0]);
        end
        checks++; if (dst_balance !== 32'd0) begin errors++; $display("FAIL dm_dst_bal: got %0d need 0", dst_balance); end
    endtask

    task automatic test_src_miss;
        int w, cyc;
        reload_tbl();
        push_req(32'h55, 32'h22, 32'd5, w);
        wait_done(cyc);
        checks++; if (status !== 3'd1) begin errors++; $display("FAIL sm_status: got %0d need 1", status); end
        checks++; if (n_cmds != 2 || acct_bal[1] !== 32'd50) begin
            errors++; $display("FAIL sm_store: cmds=%0d bal22=%0d need 2/50", n_cmds, acct_bal[1]);
        end
    endtask

    task automatic test_self;
        int w, cyc;
        reload_tbl();
        push_req(32'h33, 32'h33, 32'd1, w);
        wait_done(cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL self_latency: done in cycle %0d need 3", cyc); end
        checks++; if (status !== 3'd4) begin errors++; $display("FAIL self_status: got %0d need 4", status); end
        @(negedge clock);
        checks++; if (en_seen !== 1'b0) begin errors++; $display("FAIL self_store_en: store_en seen=%b need 0", en_seen); end
    endtask

    task automatic test_back_to_back;
        int w, base, n;
        logic [31:0] rs [6], rd [6], ra [6];
        logic [2:0]  es [6];
        logic [31:0] esrc [6], edst [6];
        rs[0]=32'h11; rd[0]=32'h22; ra[0]=32'd10;  es[0]=3'd0; esrc[0]=32'd90;  edst[0]=32'd60;
        rs[1]=32'h22; rd[1]=32'h11; ra[1]=32'd20;  es[1]=3'd0; esrc[1]=32'd40;  edst[1]=32'd110;
        rs[2]=32'h33; rd[2]=32'h33; ra[2]=32'd1;   es[2]=3'd4; esrc[2]=32'd0;   edst[2]=32'd0;
        rs[3]=32'h11; rd[3]=32'h99; ra[3]=32'd3;   es[3]=3'd2; esrc[3]=32'd0;   edst[3]=32'd0;
        rs[4]=32'h44; rd[4]=32'h11; ra[4]=32'd500; es[4]=3'd0; esrc[4]=32'd500; edst[4]=32'd610;
`ifdef BALANCE_CHECK_EN
        rs[5]=32'h33; rd[5]=32'h22; ra[5]=32'd10;  es[5]=3'd3; esrc[5]=32'd7;   edst[5]=32'd0;
`else
        rs[5]=32'h33; rd[5]=32'h22; ra[5]=32'd10;  es[5]=3'd0; esrc[5]=32'hFFFF_FFFD; edst[5]=32'd50;
`endif
        reload_tbl();
        base = mon_cnt;
        for (int i = 0; i < 6; i++) begin
            push_req(rs[i], rd[i], ra[i], w);
            if (i == 4) begin
                checks++; if (w != 0) begin errors++; $display("FAIL b2b_fourth_accept: waited %0d need 0", w); end
            end
            if (i == 5) begin
                checks++; if (w == 0) begin errors++; $display("FAIL b2b_full: fifth request accepted at once, need in_ready=0"); end
            end
        end
        n = 0;
        while (mon_cnt < base + 6 && n < 400) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (mon_cnt < base + 6) begin
            errors++; $display("FAIL b2b_count: %0d dones need 6", mon_cnt - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (mon_status[base+i] !== es[i] || mon_src[base+i] !== esrc[i] || mon_dst[base+i] !== edst[i]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %0d/%h/%h need %0d/%h/%h", i, mon_status[base+i],
                             mon_src[base+i], mon_dst[base+i], es[i], esrc[i], edst[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int w, n, base, en_cnt;
        bit hit;
        reload_tbl();
        push_req(32'h11, 32'h22, 32'd5, w);
        push_req(32'h44, 32'h22, 32'd1, w);
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (store_en === 1'b1 && store_signal === 2'd2 && store_kind === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rm_credit_timeout: CREDIT not reached"); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (store_en !== 1'b0 || done !== 1'b0 || status !== 3'd0) begin
            errors++; $display("FAIL rm_async: en=%b done=%b status=%0d need 0/0/0", store_en, done, status);
        end
        checks++; if (in_ready !== 1'b1 || src_balance !== 32'h0) begin
            errors++; $display("FAIL rm_fifo: in_ready=%b src_bal=%h need 1/0", in_ready, src_balance);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        base = mon_cnt;
        en_cnt = 0;
        for (n = 0; n < 30; n++) begin
            @(negedge clock);
            if (store_en === 1'b1) en_cnt++;
        end
        checks++; if (mon_cnt != base || en_cnt != 0) begin
            errors++; $display("FAIL rm_abandon: dones=%0d en_cycles=%0d need 0/0", mon_cnt - base, en_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_transfer_ok();
        test_overdraw();
        test_dst_miss();
        test_src_miss();
        test_self();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
